// File: rtl/dual_rail_deserializer.sv
// Dual-rail (4-phase, return-to-zero) channel receiver that assembles
// WIDTH bits into a word, handshakes each bit with ack_out and hands
// finished words to a valid/ready consumer.
module dual_rail_deserializer #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit0_in,
    input  logic             bit1_in,
    output logic             ack_out,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             code_err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        WAIT_DATA,
        WAIT_SPACER
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync0;
    logic [SYNC_STAGES-1:0] r_sync1;
    state_t                 r_state;
    state_t                 w_nextState;
    logic                   r_ack;
    logic [CW-1:0]          r_cnt;
    logic [WIDTH-1:0]       r_shift;
    logic [WIDTH-1:0]       r_dataOut;
    logic                   r_dataValid;
    logic                   r_prevIllegal;
    logic                   r_codeErr;

    logic                   w_s0;
    logic                   w_s1;
    logic                   w_isData;
    logic                   w_isSpacer;
    logic                   w_isIllegal;
    logic                   w_lastBit;
    logic                   w_stall;
    logic                   w_accept;
    logic [WIDTH-1:0]       w_word;

    // Both rails are asynchronous to clk, so each gets its own flop chain;
    // nothing downstream ever looks at the raw pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync0 <= '0;
            r_sync1 <= '0;
        end else begin
            r_sync0 <= {r_sync0[SYNC_STAGES-2:0], bit0_in};
            r_sync1 <= {r_sync1[SYNC_STAGES-2:0], bit1_in};
        end
    end

    assign w_s0        = r_sync0[SYNC_STAGES-1];
    assign w_s1        = r_sync1[SYNC_STAGES-1];
    assign w_isData    = w_s0 ^ w_s1;
    assign w_isSpacer  = ~w_s0 & ~w_s1;
    assign w_isIllegal = w_s0 & w_s1;

    // The last bit of a word can only be taken when the output register is
    // free or being emptied this very cycle; earlier bits never wait.
    assign w_lastBit = (r_cnt == CW'(WIDTH - 1));
    assign w_stall   = w_lastBit & r_dataValid & ~data_ready;

    // Handshake sequencing: accept a data code once, then wait for the
    // spacer before accepting the next one. The illegal code matches
    // neither branch, so it leaves everything where it was.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        case (r_state)
            WAIT_DATA: begin
                if (w_isData && !w_stall) begin
                    w_accept    = 1'b1;
                    w_nextState = WAIT_SPACER;
                end
            end
            WAIT_SPACER: begin
                if (w_isSpacer) begin
                    w_nextState = WAIT_DATA;
                end
            end
            default: w_nextState = WAIT_DATA;
        endcase
    end

    // State register; ack is registered alongside it so it mirrors the
    // state one-for-one and lands exactly one edge after the synchronizer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT_DATA;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_ack   <= (w_nextState == WAIT_SPACER);
        end
    end

    // The partial word with the incoming bit dropped into slot cnt; this is
    // both the next shift register value and the completed word on the last bit.
    always_comb begin
        w_word = r_shift;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_cnt == CW'(i)) begin
                w_word[i] = w_s1;
            end
        end
    end

    // Bit assembly and output register: a completed word loads data_out and
    // keeps valid set even if the previous word is consumed on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_shift     <= '0;
            r_dataOut   <= '0;
            r_dataValid <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_lastBit) begin
                    r_dataOut <= w_word;
                    r_shift   <= '0;
                    r_cnt     <= '0;
                end else begin
                    r_shift <= w_word;
                    r_cnt   <= r_cnt + CW'(1);
                end
            end
            if (w_accept && w_lastBit) begin
                r_dataValid <= 1'b1;
            end else if (data_ready) begin
                r_dataValid <= 1'b0;
            end
        end
    end

    // Flag only the first cycle of an illegal code so a held fault gives a
    // single pulse rather than a stream of them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prevIllegal <= 1'b0;
            r_codeErr     <= 1'b0;
        end else begin
            r_prevIllegal <= w_isIllegal;
            r_codeErr     <= w_isIllegal & ~r_prevIllegal;
        end
    end

    assign ack_out    = r_ack;
    assign data_out   = r_dataOut;
    assign data_valid = r_dataValid;
    assign code_err   = r_codeErr;

endmodule

// File: tb/tb_dual_rail_deserializer.sv
// Self-checking bench for dual_rail_deserializer: directed handshake,
// stall, illegal-code and reset scenarios followed by random traffic,
// all checked against a bit-queue / word-queue reference model.
module tb_dual_rail_deserializer;

    logic       clk;
    logic       rst_n;
    logic       bit0_in;
    logic       bit1_in;
    logic       ack_out;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       code_err;

    int         testCount = 0;
    int         failCount = 0;
    int         errCount  = 0;
    bit         randomReady = 0;

    // Reference model: bits accepted so far in the current word, and the
    // words the consumer should see, oldest first.
    logic       bitsQ[$];
    logic [7:0] expQ[$];

    dual_rail_deserializer #(
        .WIDTH      (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit0_in   (bit0_in),
        .bit1_in   (bit1_in),
        .ack_out   (ack_out),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .code_err  (code_err)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Record an acknowledged bit; every eighth bit completes a word, first bit in the LSB.
    task automatic modelAccept(input logic b);
        logic [7:0] word;
        bitsQ.push_back(b);
        if (bitsQ.size() == 8) begin
            word = '0;
            for (int i = 0; i < 8; i++) begin
                word[i] = bitsQ[i];
            end
            expQ.push_back(word);
            bitsQ.delete();
        end
    endtask

    // Wait (bounded) on negedges for ack_out to reach a level, optionally
    // randomizing data_ready while waiting; the final level is always checked.
    task automatic waitAck(input logic level, input string tag, input int limit);
        int n = 0;
        while (ack_out !== level && n < limit) begin
            @(negedge clk);
            if (randomReady) data_ready = 1'($urandom_range(0, 1));
            n++;
        end
        checkOutput(tag, {31'd0, ack_out}, {31'd0, level});
    endtask

    // One full 4-phase transfer of a single bit.
    task automatic applyStimulus(input logic b);
        @(negedge clk);
        if (b) bit1_in = 1'b1;
        else   bit0_in = 1'b1;
        waitAck(1'b1, "ackRise", 200);
        modelAccept(b);
        bit0_in = 1'b0;
        bit1_in = 1'b0;
        waitAck(1'b0, "ackFall", 200);
    endtask

    // Consumer-side scoreboard: sampled after the negedge so data_ready and
    // the DUT outputs are both settled for the upcoming rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && data_valid && data_ready) begin
                if (expQ.size() == 0) checkOutput("unexpectedWord", expQ.size(), 1);
                else                  checkOutput("consumedWord", {24'd0, data_out}, {24'd0, expQ.pop_front()});
            end
            if (code_err) errCount++;
        end
    end

    // Main scenario sequence.
    initial begin
        logic [7:0] tmpWord;
        logic       bits4D[7];
        int         errBase;

        rst_n      = 1'b1;
        bit0_in    = 1'b0;
        bit1_in    = 1'b0;
        data_ready = 1'b0;
        #1 rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetAck",   {31'd0, ack_out},    0);
        checkOutput("resetValid", {31'd0, data_valid}, 0);
        checkOutput("resetErr",   {31'd0, code_err},   0);
        checkOutput("resetData",  {24'd0, data_out},   0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Exact ack latency: two synchronizer edges plus one FSM edge.
        bit1_in = 1'b1;
        @(negedge clk); checkOutput("ackRiseEdge1", {31'd0, ack_out}, 0);
        @(negedge clk); checkOutput("ackRiseEdge2", {31'd0, ack_out}, 0);
        @(negedge clk); checkOutput("ackRiseEdge3", {31'd0, ack_out}, 1);
        modelAccept(1'b1);
        repeat (4) @(negedge clk);
        checkOutput("ackHeld", {31'd0, ack_out}, 1);
        bit1_in = 1'b0;
        @(negedge clk); checkOutput("ackFallEdge1", {31'd0, ack_out}, 1);
        @(negedge clk); checkOutput("ackFallEdge2", {31'd0, ack_out}, 1);
        @(negedge clk); checkOutput("ackFallEdge3", {31'd0, ack_out}, 0);

        // Remaining bits of the sequence 1,0,1,1,0,0,1,0.
        bits4D = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) applyStimulus(bits4D[i]);
        checkOutput("word4DValid", {31'd0, data_valid}, 1);
        checkOutput("word4DData",  {24'd0, data_out}, 32'h4D);
        checkOutput("noCodeErr", errCount, 0);

        // Drain it and confirm valid drops.
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        checkOutput("validCleared", {31'd0, data_valid}, 0);

        // Leave 0xA5 pending, then present 0x3C: bit 7 must stall.
        tmpWord = 8'hA5;
        for (int i = 0; i < 8; i++) applyStimulus(tmpWord[i]);
        tmpWord = 8'h3C;
        for (int i = 0; i < 7; i++) applyStimulus(tmpWord[i]);
        @(negedge clk);
        if (tmpWord[7]) bit1_in = 1'b1;
        else            bit0_in = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("stallNoAck",  {31'd0, ack_out},    0);
        checkOutput("stallValid",  {31'd0, data_valid}, 1);
        checkOutput("stallHold",   {24'd0, data_out},   {24'd0, expQ[0]});
        data_ready = 1'b1;
        waitAck(1'b1, "stallRelease", 50);
        modelAccept(tmpWord[7]);
        checkOutput("sameCycleValid", {31'd0, data_valid}, 1);
        checkOutput("sameCycleWord",  {24'd0, data_out},   {24'd0, expQ[expQ.size()-1]});
        data_ready = 1'b0;
        bit0_in    = 1'b0;
        bit1_in    = 1'b0;
        waitAck(1'b0, "stallAckFall", 50);

        // Illegal code held mid-word: one pulse, no ack, bit count untouched.
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        errBase = errCount;
        @(negedge clk);
        bit0_in = 1'b1;
        bit1_in = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("illegalNoAck", {31'd0, ack_out}, 0);
        bit0_in = 1'b0;
        bit1_in = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("singleErrPulse", errCount - errBase, 1);
        applyStimulus(1'b1);

        // Reset in the middle of the fourth handshake discards everything.
        @(negedge clk);
        bit1_in = 1'b1;
        waitAck(1'b1, "preResetAck", 50);
        rst_n = 1'b0;
        #1;
        checkOutput("midResetAck",   {31'd0, ack_out},    0);
        checkOutput("midResetValid", {31'd0, data_valid}, 0);
        bitsQ.delete();
        expQ.delete();
        bit1_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1);
        checkOutput("postResetWord", {24'd0, data_out}, 32'hFF);

        // Random traffic with a randomly stalling consumer.
        randomReady = 1'b1;
        for (int i = 0; i < 40; i++) applyStimulus(1'($urandom_range(0, 1)));
        randomReady = 1'b0;
        @(negedge clk);
        data_ready = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("allConsumed", expQ.size(), 0);
        checkOutput("noPartialBits", bitsQ.size(), 0);
        checkOutput("finalErrCount", errCount, errBase + 1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/dual_rail_deserializer.md
DUAL_RAIL_DESERIALIZER -- requirements
Module: dual_rail_deserializer

Interface
REQ-001 Parameter WIDTH, default 8, is the number of dual-rail bits assembled per output word.
REQ-002 Parameter SYNC_STAGES, default 2, is the flip-flop depth of the input synchronizer (minimum 2).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 bit0_in  input  1  dual-rail "logic 0" rail from the channel receiver; asynchronous to clk.
REQ-006 bit1_in  input  1  dual-rail "logic 1" rail from the channel receiver; asynchronous to clk.
REQ-007 ack_out  output  1  4-phase acknowledge back to the channel, registered.
REQ-008 data_out  output  WIDTH  assembled word, registered, bit 0 = first bit received.
REQ-009 data_valid  output  1  data_out holds an unconsumed word.
REQ-010 data_ready  input  1  consumer accepts data_out on a cycle where data_valid=1 and data_ready=1.
REQ-011 code_err  output  1  one-cycle pulse on an illegal rail code (both rails high).

Function
REQ-012 bit0_in and bit1_in SHALL each pass through a SYNC_STAGES flip-flop synchronizer; only synchronized values (s0, s1) are used by the logic.
REQ-013 Codes: (s1,s0)=00 spacer, 01 logic 0, 10 logic 1, 11 illegal.
REQ-014 FSM states SHALL be WAIT_DATA (ack_out=0) and WAIT_SPACER (ack_out=1).
REQ-015 WAIT_DATA, code 01/10, not stalled: shift bit into shift register at index cnt, cnt+1, set ack_out=1, go to WAIT_SPACER.
REQ-016 WAIT_DATA, code 00: hold state, no change.
REQ-017 Any state, code 11: pulse code_err for exactly one cycle per clk the code persists is NOT allowed; code_err SHALL pulse once on entry to 11 and state, cnt, ack_out SHALL be unchanged.
REQ-018 WAIT_SPACER, code 00: ack_out=0, go to WAIT_DATA; codes 01/10 hold state (no double count).
REQ-019 ack_out SHALL change exactly SYNC_STAGES+1 rising edges after the corresponding rail transition on the input pin.
REQ-020 cnt SHALL be ceil(log2(WIDTH+1)) bits and wrap to 0 when the WIDTH-th bit is accepted.
REQ-021 On accepting the WIDTH-th bit, the completed word (including that bit) SHALL load data_out and data_valid SHALL be 1 the following cycle.
REQ-022 Stall: if cnt=WIDTH-1 and data_valid=1 and data_ready=0, a data code SHALL NOT be accepted (ack_out stays 0) until the output register drains.
REQ-023 data_valid SHALL clear on a cycle with data_ready=1 unless a new word loads that same cycle, in which case data_valid stays 1 and data_out takes the new word.
REQ-024 data_out SHALL remain stable while data_valid=1 and data_ready=0.
REQ-025 Bits 0..WIDTH-2 SHALL be accepted regardless of output-register occupancy.

Reset
REQ-026 rst_n=0 SHALL asynchronously force ack_out=0, data_valid=0, code_err=0, data_out=0, cnt=0, shift register=0, synchronizer flops=0, state=WAIT_DATA.
REQ-027 Reset asserted mid-word SHALL discard all partial bits; the first token after rst_n rises is bit 0 of a new word.
REQ-028 After rst_n deasserts, the first token SHALL be accepted only once s0/s1 reflect the pins (SYNC_STAGES cycles).

Verification
REQ-029 WIDTH=8, send bits 1,0,1,1,0,0,1,0 with full 4-phase handshakes -> data_out=8'h4D, data_valid=1 one cycle after 8th ack rises, code_err never 1.
REQ-030 Raise bit1_in and hold -> ack_out rises exactly 3 clk edges later (SYNC_STAGES=2), stays high until bit1_in falls, falls 3 edges after; cnt increments once.
REQ-031 Word 8'hA5 pending with data_ready=0, send 7 bits of 8'h3C then 8th bit -> 8th bit not acked; assert data_ready -> 8th bit acked, data_out=8'h3C, data_valid=1.
REQ-032 data_ready=1 on the same cycle a new word loads -> data_valid stays 1, data_out changes to new word, no word lost.
REQ-033 Drive bit0_in=bit1_in=1 for 5 cycles -> single code_err pulse, ack_out and cnt unchanged; release to 00 then send bit -> normal acceptance.
REQ-034 Send 3 bits, assert rst_n=0 mid-handshake -> ack_out=0 and data_valid=0 immediately; next 8 bits 8'hFF -> data_out=8'hFF.
